// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The slave modport is the loader; master is the stream source / memory side.
interface imem_loader_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     in_valid;
    logic [7:0]               in_data;
    logic                     in_ready;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: length header, little-endian payload words,
// XOR checksum; holds the CPU until a verified image has been written.
module imem_loader #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = {ADDRESS_WIDTH{1'b0}},
    parameter int                       MAX_WORDS     = 1024,
    localparam int                      CW            = $clog2(MAX_WORDS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic [CW-1:0] words_written
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam logic [CW-1:0] ONE_CW = CW'(1'b1);

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [1:0]               lane_r;
    logic [CW-1:0]            idx_r;
    logic [7:0]               xor_r;
    logic [31:0]              len_r;
    logic [23:0]              word_r;
    logic                     in_ready_r;
    logic                     mem_we_r;
    logic [ADDRESS_WIDTH-1:0] mem_addr_r;
    logic [31:0]              mem_wdata_r;
    logic                     cpu_hold_r;
    logic                     done_r;
    logic                     error_r;
    logic [CW-1:0]            ww_r;
    logic                     in_ready_nxt_s;
    logic                     cpu_hold_nxt_s;
    logic                     done_nxt_s;
    logic                     error_nxt_s;
    logic                     accept_s;
    logic                     restart_s;
    logic                     lane_last_s;
    logic                     last_word_s;
    logic [31:0]              len_full_s;
    logic [31:0]              word_full_s;
    logic [ADDRESS_WIDTH-1:0] addr_off_s;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    assign accept_s    = bus.in_valid & in_ready_r;
    assign restart_s   = start & ((state_r == ST_IDLE) | (state_r == ST_DONE) | (state_r == ST_ERR));
    assign lane_last_s = (lane_r == 2'd3);
    assign len_full_s  = {bus.in_data, len_r[31:8]};
    assign word_full_s = {bus.in_data, word_r};
    assign last_word_s = (({{(32-CW){1'b0}}, idx_r} + 32'd1) == len_r);
    assign addr_off_s  = ADDRESS_WIDTH'({idx_r, 2'b00});

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; a start outside IDLE/DONE/ERR has no effect
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_nxt_s = ST_LEN;
                else       state_nxt_s = state_r;
            end
            ST_LEN: begin
                if (accept_s && lane_last_s) begin
                    if (len_full_s > 32'(MAX_WORDS)) state_nxt_s = ST_ERR;
                    else if (len_full_s == 32'd0)    state_nxt_s = ST_CSUM;
                    else                             state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_LEN;
                end
            end
            ST_DATA: begin
                if (accept_s && lane_last_s && last_word_s) state_nxt_s = ST_CSUM;
                else                                        state_nxt_s = ST_DATA;
            end
            ST_CSUM: begin
                if (accept_s) begin
                    if (bus.in_data == xor_r) state_nxt_s = ST_DONE;
                    else                      state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_CSUM;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Status outputs derived from the state being entered, so they register with it
    always_comb begin
        in_ready_nxt_s = 1'b0;
        cpu_hold_nxt_s = 1'b1;
        done_nxt_s     = 1'b0;
        error_nxt_s    = 1'b0;
        case (state_nxt_s)
            ST_LEN, ST_DATA, ST_CSUM: in_ready_nxt_s = 1'b1;
            ST_DONE: begin
                done_nxt_s     = 1'b1;
                cpu_hold_nxt_s = 1'b0;
            end
            ST_ERR:  error_nxt_s = 1'b1;
            default: in_ready_nxt_s = 1'b0;
        endcase
    end

    // Status output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_r <= 1'b0;
            cpu_hold_r <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            in_ready_r <= in_ready_nxt_s;
            cpu_hold_r <= cpu_hold_nxt_s;
            done_r     <= done_nxt_s;
            error_r    <= error_nxt_s;
        end
    end

    // Byte assembly, running checksum and the one-cycle memory write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_r      <= 2'd0;
            idx_r       <= {CW{1'b0}};
            xor_r       <= 8'h00;
            len_r       <= 32'd0;
            word_r      <= 24'd0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= BASE_ADDR;
            mem_wdata_r <= 32'd0;
            ww_r        <= {CW{1'b0}};
        end else if (restart_s) begin
            lane_r   <= 2'd0;
            idx_r    <= {CW{1'b0}};
            xor_r    <= 8'h00;
            len_r    <= 32'd0;
            word_r   <= 24'd0;
            mem_we_r <= 1'b0;
            ww_r     <= {CW{1'b0}};
        end else begin
            mem_we_r <= 1'b0;
            if (accept_s) begin
                case (state_r)
                    ST_LEN: begin
                        len_r  <= len_full_s;
                        xor_r  <= csum_step(xor_r, bus.in_data);
                        lane_r <= lane_r + 2'd1;
                    end
                    ST_DATA: begin
                        word_r <= word_full_s[31:8];
                        xor_r  <= csum_step(xor_r, bus.in_data);
                        lane_r <= lane_r + 2'd1;
                        if (lane_last_s) begin
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= BASE_ADDR + addr_off_s;
                            mem_wdata_r <= word_full_s;
                            idx_r       <= idx_r + ONE_CW;
                            ww_r        <= idx_r + ONE_CW;
                        end else begin
                            idx_r <= idx_r;
                        end
                    end
                    default: lane_r <= lane_r;
                endcase
            end else begin
                lane_r <= lane_r;
            end
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = DATA_WIDTH'(mem_wdata_r);
    assign cpu_hold       = cpu_hold_r;
    assign done           = done_r;
    assign error          = error_r;
    assign words_written  = ww_r;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory: accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and writes them to consecutive instruction-memory addresses. It sits beside the fetch path, on the write port of the instruction memory, and holds the CPU (PC and fetch) until a complete, checksum-verified program image has been written.

## Interface
- ADDRESS_WIDTH, 32, width of instruction-memory byte address
- DATA_WIDTH, 32, instruction word width (fixed at 32; other values unsupported)
- BASE_ADDR, 32'h0, byte address of the first loaded word
- MAX_WORDS, 1024, largest accepted image length in words
- CW = $clog2(MAX_WORDS+1), derived width of word counters

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  begin a load; honoured only in IDLE, DONE, ERR
- in_valid  in  1  in_data holds a byte
- in_data  in  8  stream byte
- in_ready  out  1  loader can take a byte; a byte transfers on in_valid & in_ready at a clock edge
- mem_we  out  1  one-cycle instruction-memory write strobe
- mem_addr  out  ADDRESS_WIDTH  write byte address
- mem_wdata  out  DATA_WIDTH  write word
- cpu_hold  out  1  keep PC in reset / fetch stalled
- done  out  1  image loaded and verified (sticky)
- error  out  1  length or checksum failure (sticky)
- words_written  out  CW  words written in the current/last load

## Operation
- Image format: 4-byte little-endian length L (words), then 4·L payload bytes (little-endian words), then 1 checksum byte = XOR of all header and payload bytes.
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- IDLE: in_ready=0. start → LEN; clear byte lane, word index, running XOR, words_written, done, error; cpu_hold=1.
- LEN: in_ready=1; shift in 4 bytes (first byte = bits 7:0). On 4th byte: L > MAX_WORDS → ERR; L == 0 → CSUM; else → DATA.
- DATA: in_ready=1; byte lane counter 0..3. On lane-3 byte: word complete; next cycle mem_we=1, mem_addr=BASE_ADDR+4·index, mem_wdata=assembled word; index and words_written increment. After word L-1 completes → CSUM.
- CSUM: in_ready=1; on received byte: equal to running XOR → DONE, else → ERR.
- DONE: done=1, cpu_hold=0, in_ready=0. ERR: error=1, cpu_hold=1, in_ready=0. Both remain until start.
- start while in LEN/DATA/CSUM is ignored.
- Running XOR covers every accepted header and payload byte, never the checksum byte.
- mem_addr arithmetic is modulo 2^ADDRESS_WIDTH; no range check beyond MAX_WORDS.
- Partially written words are never written; memory contents are not rolled back on ERR.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, done=0, error=0, words_written=0; state IDLE.
- Reset asserted mid-load: immediate return to IDLE with the values above; any word whose write strobe has not yet occurred is dropped.
- start sampled at edge N → in_ready=1 from cycle N+1.
- Throughput: one byte per cycle; in_ready stays 1 through LEN/DATA/CSUM, including during the mem_we cycle.
- Write latency: mem_we high exactly one cycle, the cycle after the edge that accepted the lane-3 byte; mem_addr/mem_wdata valid in that cycle and held until the next write.
- words_written updates at the same edge that raises mem_we.
- in_valid gaps stall progress without side effects; in_data ignored when in_valid=0.
- done/error/cpu_hold change at the edge that accepts the checksum byte (or 4th length byte for an oversize L).
- The last mem_we is always observed before done rises.

## Test plan
- Nominal: start; bytes 02 00 00 00, 13 05 50 00, 93 05 a0 00, 72 → writes 0x00500513 @BASE_ADDR, 0x00a00593 @BASE_ADDR+4; done=1, cpu_hold=0, words_written=2, error=0.
- Bad checksum: same stream ending 73 → both writes occur, then error=1, done=0, cpu_hold=1, in_ready=0.
- Zero length: bytes 00 00 00 00, 00 → no mem_we, done=1, words_written=0.
- Oversize: bytes 01 04 00 00 (L=1025, MAX_WORDS=1024) → error=1 right after 4th byte, no mem_we, in_ready=0; later start restarts cleanly.
- Backpressure/gaps: nominal stream with in_valid deasserted on random cycles, plus start pulses mid-load → identical writes and result to nominal.
- Reset mid-load: rst low after 6 payload bytes → one word written, then all outputs at reset values; a fresh start with nominal stream completes with done=1.
